cpcs_encoder_nl: RTL and testbench

Multi-lane, parametrised 8b/10b encoder for the CorePCS transmit path. It encodes LANES bytes per clock into LANES 10-bit symbols. Running disparity (RD) is chained lane-to-lane within a word and carried across words. It adds a valid qualifier, per-word forced disparity and per-lane invalid-K flags, and sits between the PCS transmit datapath and the SerDes parallel interface.

---
 rtl/cpcs_encoder_nl.sv | 191 +++++++++++++++++++
 tb/tb_cpcs_encoder_nl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpcs_encoder_nl.sv
// Multi-lane 8b/10b encoder for the CorePCS transmit path.
// Two-stage pipeline: input register, then encode with lane-chained running disparity.
module cpcs_encoder_nl #(
    parameter int LANES = 2
) (
    input  logic                  CLK,
    input  logic                  aresetn,
    input  logic [8*LANES-1:0]    DIN,
    input  logic [LANES-1:0]      KIN,
    input  logic                  VALID_IN,
    input  logic                  FORCE_DISP,
    input  logic                  DISP_SEL,
    output logic [10*LANES-1:0]   DOUT,
    output logic                  VALID_OUT,
    output logic [LANES-1:0]      INVALID_K,
    output logic                  RD_OUT
);

    localparam logic [9:0] K28_5_RDM = 10'b0011111010;

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       invk;
    } lane_enc_t;

    // 5b/6b sub-block in its RD- form (abcdei, a is the MSB)
    function automatic logic [5:0] enc5b6b(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;
            5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;
            5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;
            5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;
            5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;
            5'd9:  return 6'b100101;
            5'd10: return 6'b010101;
            5'd11: return 6'b110100;
            5'd12: return 6'b001101;
            5'd13: return 6'b101100;
            5'd14: return 6'b011100;
            5'd15: return 6'b010111;
            5'd16: return 6'b011011;
            5'd17: return 6'b100011;
            5'd18: return 6'b010011;
            5'd19: return 6'b110010;
            5'd20: return 6'b001011;
            5'd21: return 6'b101010;
            5'd22: return 6'b011010;
            5'd23: return 6'b111010;
            5'd24: return 6'b110011;
            5'd25: return 6'b100110;
            5'd26: return 6'b010110;
            5'd27: return 6'b110110;
            5'd28: return 6'b001110;
            5'd29: return 6'b101110;
            5'd30: return 6'b011110;
            default: return 6'b101011;
        endcase
    endfunction

    // 3b/4b sub-block in its form for RD- after the 6b sub-block (fghj)
    function automatic logic [3:0] enc3b4b(input logic [2:0] y, input logic alt7);
        case (y)
            3'd0:    return 4'b1011;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b1100;
            3'd4:    return 4'b1101;
            3'd5:    return 4'b1010;
            3'd6:    return 4'b0110;
            default: return alt7 ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    function automatic lane_enc_t encode_lane(
        input logic [7:0] b,
        input logic       k,
        input logic       rd_in
    );
        lane_enc_t  r;
        logic [4:0] x;
        logic [2:0] y;
        logic       k_ok;
        logic       kk;
        logic       unbal6;
        logic       unbal4;
        logic       rd6;
        logic       alt7;
        logic [5:0] six;
        logic [3:0] four_m;
        logic [3:0] four_p;
        logic [3:0] four;

        x    = b[4:0];
        y    = b[7:5];
        k_ok = (x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
        kk   = k && k_ok;

        six    = (kk && (x == 5'd28)) ? 6'b001111 : enc5b6b(x);
        unbal6 = ($countones(six) != 3);
        if (rd_in && (unbal6 || (x == 5'd7))) begin
            six = ~six;
        end
        rd6 = rd_in ^ unbal6;

        alt7 = kk || (rd6 ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                          : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
        four_m = enc3b4b(y, alt7);
        unbal4 = ($countones(four_m) != 2);
        four_p = (unbal4 || (y == 3'd3)) ? ~four_m : four_m;
        // Control characters use the RD+ data column as their base and invert it at RD-,
        // which also covers the otherwise-balanced K28.1/.2/.5/.6 alternation.
        if (kk) begin
            four = rd6 ? four_p : ~four_p;
        end else begin
            four = rd6 ? four_p : four_m;
        end

        r.sym  = {six, four};
        r.rd   = rd6 ^ unbal4;
        r.invk = k && !k_ok;
        return r;
    endfunction

    logic [8*LANES-1:0]  s1_din;
    logic [LANES-1:0]    s1_kin;
    logic                s1_valid;
    logic                s1_force;
    logic                s1_sel;
    logic                rd_q;

    logic [LANES:0]      rd_chain;
    logic [10*LANES-1:0] enc_dout;
    logic [LANES-1:0]    enc_invk;
    lane_enc_t           lane_r;

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            s1_din   <= '0;
            s1_kin   <= '0;
            s1_valid <= 1'b0;
            s1_force <= 1'b0;
            s1_sel   <= 1'b0;
        end else begin
            s1_din   <= DIN;
            s1_kin   <= KIN;
            s1_valid <= VALID_IN;
            s1_force <= FORCE_DISP;
            s1_sel   <= DISP_SEL;
        end
    end

    // RD ripples lane 0 -> LANES-1 within the cycle so back-to-back words need no bubble
    always_comb begin
        rd_chain    = '0;
        enc_dout    = '0;
        enc_invk    = '0;
        lane_r      = '0;
        rd_chain[0] = s1_force ? s1_sel : rd_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_r               = encode_lane(s1_din[8*i +: 8], s1_kin[i], rd_chain[i]);
            enc_dout[10*i +: 10] = lane_r.sym;
            enc_invk[i]          = lane_r.invk;
            rd_chain[i+1]        = lane_r.rd;
        end
    end

    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            rd_q      <= 1'b0;
            DOUT      <= {LANES{K28_5_RDM}};
            INVALID_K <= '0;
            VALID_OUT <= 1'b0;
        end else begin
            VALID_OUT <= s1_valid;
            if (s1_valid) begin
                DOUT      <= enc_dout;
                INVALID_K <= enc_invk;
                rd_q      <= rd_chain[LANES];
            end
        end
    end

    assign RD_OUT = rd_q;

endmodule

// File: tb/tb_cpcs_encoder_nl.sv
// Self-checking bench for cpcs_encoder_nl (LANES=4): table-driven 8b/10b reference
// model compared every cycle, plus hand-computed literal words.
module tb_cpcs_encoder_nl;

    localparam int LANES = 4;

    logic        CLK = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] DIN;
    logic [3:0]  KIN;
    logic        VALID_IN;
    logic        FORCE_DISP;
    logic        DISP_SEL;
    logic [39:0] DOUT;
    logic        VALID_OUT;
    logic [3:0]  INVALID_K;
    logic        RD_OUT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cpcs_encoder_nl #(.LANES(LANES)) dut (
        .CLK        (CLK),
        .aresetn    (aresetn),
        .DIN        (DIN),
        .KIN        (KIN),
        .VALID_IN   (VALID_IN),
        .FORCE_DISP (FORCE_DISP),
        .DISP_SEL   (DISP_SEL),
        .DOUT       (DOUT),
        .VALID_OUT  (VALID_OUT),
        .INVALID_K  (INVALID_K),
        .RD_OUT     (RD_OUT)
    );

    // Code tables in the usual two-column form, indexed by the RD seen by each sub-block
    localparam logic [5:0] T6M [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4M [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KC [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                       8'hF7, 8'hFB, 8'hFD, 8'hFE};

    typedef struct packed {
        logic [39:0] dout;
        logic [3:0]  invk;
        logic        rd;
    } word_t;

    function automatic word_t model_word(input logic [31:0] d, input logic [3:0] k, input logic rd0);
        word_t      w;
        logic       rd;
        logic       rd6;
        logic       kv;
        logic       kk;
        logic [7:0] b;
        int         x;
        int         y;
        int         n;
        logic [5:0] six;
        logic [3:0] four;
        logic [9:0] sym;
        w  = '0;
        rd = rd0;
        for (int i = 0; i < LANES; i++) begin
            b  = d[8*i +: 8];
            x  = int'(b[4:0]);
            y  = int'(b[7:5]);
            kv = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
            kk = k[i] && kv;
            w.invk[i] = k[i] && !kv;
            if (kk && x == 28) six = rd ? 6'b110000 : 6'b001111;
            else               six = rd ? T6P[x] : T6M[x];
            n   = $countones(six);
            rd6 = (n == 3) ? rd : (n > 3);
            if (kk)
                four = rd6 ? K4P[y] : K4M[y];
            else if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                                ( rd6 && (x == 11 || x == 13 || x == 14))))
                four = rd6 ? 4'b1000 : 4'b0111;
            else
                four = rd6 ? T4P[y] : T4M[y];
            sym = {six, four};
            w.dout[10*i +: 10] = sym;
            n  = $countones(sym);
            rd = (n == 5) ? rd : (n > 5);
        end
        w.rd = rd;
        return w;
    endfunction

    // Model: p_* is the word accepted last edge, m_* what the outputs must show now
    logic [39:0] m_dout;
    logic [3:0]  m_invk;
    logic        m_valid;
    logic        m_rd;
    logic        p_valid;
    logic [39:0] p_dout;
    logic [3:0]  p_invk;
    logic        p_rd;
    word_t       m_next;

    assign m_next = model_word(DIN, KIN, FORCE_DISP ? DISP_SEL : (p_valid ? p_rd : m_rd));

    always @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            m_dout  <= {4{10'b0011111010}};
            m_invk  <= '0;
            m_valid <= 1'b0;
            m_rd    <= 1'b0;
            p_valid <= 1'b0;
            p_dout  <= '0;
            p_invk  <= '0;
            p_rd    <= 1'b0;
        end else begin
            m_valid <= p_valid;
            if (p_valid) begin
                m_dout <= p_dout;
                m_invk <= p_invk;
                m_rd   <= p_rd;
            end
            p_valid <= VALID_IN;
            if (VALID_IN) begin
                p_dout <= m_next.dout;
                p_invk <= m_next.invk;
                p_rd   <= m_next.rd;
            end
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        check("model_dout",  DOUT, m_dout);
        check("model_valid", 40'(VALID_OUT), 40'(m_valid));
        check("model_invk",  40'(INVALID_K), 40'(m_invk));
        check("model_rd",    40'(RD_OUT), 40'(m_rd));
    end

    task automatic lit(input string name, input logic [39:0] d, input logic rd,
                       input logic [3:0] ik, input logic v);
        check({name, "_dout"},  DOUT, d);
        check({name, "_rd"},    40'(RD_OUT), 40'(rd));
        check({name, "_invk"},  40'(INVALID_K), 40'(ik));
        check({name, "_valid"}, 40'(VALID_OUT), 40'(v));
    endtask

    task automatic step(input logic [31:0] d, input logic [3:0] k, input logic v,
                        input logic f, input logic s);
        @(negedge CLK);
        DIN        = d;
        KIN        = k;
        VALID_IN   = v;
        FORCE_DISP = f;
        DISP_SEL   = s;
    endtask

    localparam logic [39:0] W_RST  = {4{10'b0011111010}};
    localparam logic [39:0] W_K285 = {10'b1100000101, 10'b0011111010, 10'b1100000101, 10'b0011111010};
    localparam logic [39:0] W_D00  = {4{10'b1001110100}};
    localparam logic [39:0] W_D215 = {4{10'b1010101010}};
    localparam logic [39:0] W_FRC  = {10'b1100000101, 10'b0011111010, 10'b1100000101, 10'b0110001011};
    localparam logic [39:0] W_A7   = {10'b1000110001, 10'b1000110111, 10'b1000110001, 10'b1000110111};
    localparam logic [39:0] W_IK   = {10'b1100001011, 10'b0110001011, 10'b0011111010, 10'b1001110100};
    localparam logic [39:0] W_D00P = {4{10'b0110001011}};

    initial begin
        DIN = '0; KIN = '0; VALID_IN = 1'b0; FORCE_DISP = 1'b0; DISP_SEL = 1'b0;
        #2 aresetn = 1'b0;
        #1 lit("reset", W_RST, 1'b0, 4'b0000, 1'b0);
        repeat (2) @(negedge CLK);
        aresetn = 1'b1;
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        lit("idle", W_RST, 1'b0, 4'b0000, 1'b0);

        step(32'hBCBCBCBC, 4'hF, 1'b1, 1'b0, 1'b0);                     // s1 K28.5
        step(32'hBCBCBCBC, 4'hF, 1'b1, 1'b0, 1'b0);                     // s2 K28.5
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);                     // s3 D.0.0
        lit("k285_w1", W_K285, 1'b0, 4'b0000, 1'b1);
        step(32'hB5B5B5B5, 4'h0, 1'b1, 1'b0, 1'b0);                     // s4 D.21.5
        lit("k285_w2", W_K285, 1'b0, 4'b0000, 1'b1);
        step(32'hBCBCBC00, 4'hE, 1'b1, 1'b1, 1'b1);                     // s5 forced RD+
        lit("d00", W_D00, 1'b0, 4'b0000, 1'b1);
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);                     // s6 unforced
        lit("d215", W_D215, 1'b0, 4'b0000, 1'b1);
        step(32'hF1F1F1F1, 4'h0, 1'b1, 1'b0, 1'b0);                     // s7 D.17.7
        lit("forced", W_FRC, 1'b0, 4'b0000, 1'b1);
        step(32'h1C00BC00, 4'hF, 1'b1, 1'b0, 1'b0);                     // s8 invalid K
        lit("after_force", W_D00, 1'b0, 4'b0000, 1'b1);
        step(32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0);                     // s9 gap
        lit("a7", W_A7, 1'b0, 4'b0000, 1'b1);
        step(32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0);                     // s10 gap
        lit("inv_k", W_IK, 1'b1, 4'b0101, 1'b1);
        step(32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0);                     // s11 gap
        lit("gap1", W_IK, 1'b1, 4'b0101, 1'b0);
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);                     // s12 after gap
        lit("gap2", W_IK, 1'b1, 4'b0101, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        lit("gap3", W_IK, 1'b1, 4'b0101, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        lit("post_gap", W_D00P, 1'b1, 4'b0000, 1'b1);

        for (int i = 0; i < 64; i++) begin
            step({8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)}, 4'(i ^ (i >> 2)),
                 (i % 5) != 3, (i % 7) == 0, 1'((i >> 1) & 1));
        end
        for (int i = 0; i < 24; i++) begin
            step({KC[(i+3)%12], KC[(i*5+2)%12], KC[(i*7+1)%12], KC[i%12]}, 4'hF,
                 1'b1, (i % 4) == 0, 1'((i >> 2) & 1));
        end

        step(32'h00000000, 4'h0, 1'b1, 1'b1, 1'b1);
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        #2 aresetn = 1'b0;
        #1 lit("midrst", W_RST, 1'b0, 4'b0000, 1'b0);
        @(negedge CLK);
        aresetn  = 1'b1;
        VALID_IN = 1'b0;
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        lit("rst_hold", W_RST, 1'b0, 4'b0000, 1'b0);
        step(32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        lit("rst_restart", W_D00, 1'b0, 4'b0000, 1'b1);
        repeat (3) step(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
